// File: rtl/hamming74_pkg.sv
// Shared Hamming(7,4) definitions: widths, parity positions,
// encoder FSM state encoding and the nibble -> codeword function.
package hamming74_pkg;

    localparam int DATA_W = 4;
    localparam int CW_W   = 7;

    // Parity bit positions inside the codeword
    localparam int P0_POS = 3;
    localparam int P1_POS = 5;
    localparam int P2_POS = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } enc_state_t;

    function automatic logic [CW_W-1:0] hamming74_encode(
        input logic [DATA_W-1:0] d
    );
        logic [CW_W-1:0] c;
        c         = '0;
        c[0]      = d[0];
        c[1]      = d[1];
        c[2]      = d[2];
        c[4]      = d[3];
        c[P0_POS] = d[2] ^ d[1] ^ d[0];
        c[P1_POS] = d[3] ^ d[1] ^ d[0];
        c[P2_POS] = d[3] ^ d[2] ^ d[0];
        return c;
    endfunction

endpackage

// File: rtl/hamming74_enc_comb.sv
// Pure combinational Hamming(7,4) encoder.
// Ports: data (in, 4) nibble; codeword (out, 7) c[6:0].
module hamming74_enc_comb
    import hamming74_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CW_W-1:0]   codeword
);

    assign codeword = hamming74_encode(data);

endmodule

// File: rtl/hamming74_serial_encoder.sv
// Serial Hamming(7,4) encoder: one nibble per valid/ready handshake,
// codeword shifted out LSB first, followed by GAP_CYCLES idle slots.
// Ports: clk, rst_n (async, active low), ena (global freeze),
//   data_in[3:0]/data_valid/data_ready (input handshake),
//   serial_out, serial_ena, frame_start, busy (registered outputs).
// Optional macro ERR_INJECT_EN adds err_inject and err_pos[2:0]
//   to flip one codeword bit of the accepted nibble.
module hamming74_serial_encoder
    import hamming74_pkg::*;
#(
    parameter int   GAP_CYCLES = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
`ifdef ERR_INJECT_EN
    input  logic              err_inject,
    input  logic [2:0]        err_pos,
`endif
    output logic              data_ready,
    output logic              serial_out,
    output logic              serial_ena,
    output logic              frame_start,
    output logic              busy
);

    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [2:0] GAP_LOAD =
        HAS_GAP ? 3'(GAP_CYCLES - 1) : 3'd0;

    enc_state_t      state;
    logic [2:0]      bit_cnt;
    logic [2:0]      gap_cnt;
    logic [CW_W-1:0] shreg;

    logic [CW_W-1:0] cw_raw;
    logic [CW_W-1:0] cw_tx;
    logic            last_slot;
    logic            accept;

    hamming74_enc_comb u_enc (
        .data     (data_in),
        .codeword (cw_raw)
    );

`ifdef ERR_INJECT_EN
    logic [CW_W-1:0] err_mask;
    // err_pos == 7 addresses no codeword bit, so nothing is flipped
    assign err_mask = (err_inject && err_pos != 3'd7)
                    ? (CW_W'(1) << err_pos) : '0;
    assign cw_tx = cw_raw ^ err_mask;
`else
    assign cw_tx = cw_raw;
`endif

    // Last slot of a frame is where the next nibble may be taken
    // so that consecutive frames abut without a bubble.
    assign last_slot = HAS_GAP
        ? (state == ST_GAP && gap_cnt == 3'd0)
        : (state == ST_SEND && bit_cnt == 3'd6);

    assign data_ready = rst_n && ena
                     && (state == ST_IDLE || last_slot);
    assign accept = data_valid && data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            gap_cnt     <= 3'd0;
            shreg       <= '0;
            serial_out  <= IDLE_LEVEL;
            serial_ena  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else if (ena) begin
            frame_start <= 1'b0;
            if (accept) begin
                // Bit 0 goes out immediately; the rest waits in shreg
                state       <= ST_SEND;
                bit_cnt     <= 3'd0;
                gap_cnt     <= 3'd0;
                shreg       <= {1'b0, cw_tx[CW_W-1:1]};
                serial_out  <= cw_tx[0];
                serial_ena  <= 1'b1;
                frame_start <= 1'b1;
                busy        <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        serial_out <= IDLE_LEVEL;
                        serial_ena <= 1'b0;
                        busy       <= 1'b0;
                    end
                    ST_SEND: begin
                        if (bit_cnt != 3'd6) begin
                            bit_cnt    <= bit_cnt + 3'd1;
                            serial_out <= shreg[0];
                            shreg      <= shreg >> 1;
                        end else if (HAS_GAP) begin
                            state      <= ST_GAP;
                            bit_cnt    <= 3'd0;
                            gap_cnt    <= GAP_LOAD;
                            serial_out <= IDLE_LEVEL;
                        end else begin
                            state      <= ST_IDLE;
                            bit_cnt    <= 3'd0;
                            shreg      <= '0;
                            serial_out <= IDLE_LEVEL;
                            serial_ena <= 1'b0;
                            busy       <= 1'b0;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt != 3'd0) begin
                            gap_cnt <= gap_cnt - 3'd1;
                        end else begin
                            state      <= ST_IDLE;
                            shreg      <= '0;
                            serial_out <= IDLE_LEVEL;
                            serial_ena <= 1'b0;
                            busy       <= 1'b0;
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        bit_cnt    <= 3'd0;
                        gap_cnt    <= 3'd0;
                        shreg      <= '0;
                        serial_out <= IDLE_LEVEL;
                        serial_ena <= 1'b0;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hamming74_serial_encoder.sv
// Scoreboard bench for hamming74_serial_encoder: driver pushes
// expected codewords on accept, a monitor rebuilds serial frames.
module tb_hamming74_serial_encoder;

    localparam int   GAP = 1;
    localparam logic IDL = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       serial_out;
    logic       serial_ena;
    logic       frame_start;
    logic       busy;
`ifdef ERR_INJECT_EN
    logic       err_inject;
    logic [2:0] err_pos;
`endif

    hamming74_serial_encoder #(
        .GAP_CYCLES (GAP),
        .IDLE_LEVEL (IDL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .data_in     (data_in),
        .data_valid  (data_valid),
`ifdef ERR_INJECT_EN
        .err_inject  (err_inject),
        .err_pos     (err_pos),
`endif
        .data_ready  (data_ready),
        .serial_out  (serial_out),
        .serial_ena  (serial_ena),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         start;
        logic [6:0] cw;
    } exp_t;

    // Hand-computed codewords for nibbles 0..F
    logic [6:0] cw_tab [16] = '{
        7'h00, 7'h69, 7'h2A, 7'h43, 7'h4C, 7'h25, 7'h66, 7'h0F,
        7'h70, 7'h19, 7'h5A, 7'h33, 7'h3C, 7'h55, 7'h16, 7'h7F
    };

    exp_t exp_q[$];
    int   fs_log[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   ena_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cyc %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns right after the accepting edge.
    task automatic send(input logic [3:0] nib,
                        input logic [6:0] cw);
        exp_t e;
        data_in    = nib;
        data_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            #1;
            if (data_ready) begin
                e.start = cyc + 1;
                e.cw    = cw;
                exp_q.push_back(e);
                @(posedge clk);
                return;
            end
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL send_timeout: nibble %0h never accepted", nib);
    endtask

    // Monitor: one observation per clock, 1ns after the falling edge
    initial begin : monitor
        logic       en_edge;
        logic [3:0] last;
        logic [6:0] got;
        exp_t       cur;
        int         phase;
        int         bidx;
        int         gleft;
        phase = 0;
        bidx  = 0;
        gleft = 0;
        got   = '0;
        last  = '0;
        cur.start = 0;
        cur.cw    = '0;
        forever begin
            @(posedge clk);
            en_edge = ena;
            @(negedge clk);
            #1;
            if (!rst_n) begin
                chk("rst_ser_ena", serial_ena, 0);
                chk("rst_busy", busy, 0);
                chk("rst_ready", data_ready, 0);
                chk("rst_out", serial_out, IDL);
                phase = 0;
                last = {serial_out, serial_ena, frame_start, busy};
                continue;
            end
            if (!ena) chk("ready_ena_low", data_ready, 0);
            if (!en_edge) begin
                chk("frozen",
                    {serial_out, serial_ena, frame_start, busy}, last);
                continue;
            end
            if (serial_ena) ena_cnt++;
            if (frame_start) begin
                chk("fs_mid_frame", phase, 0);
                fs_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fs_unexpected: frame_start=1 none queued");
                    phase = 0;
                end else begin
                    cur = exp_q.pop_front();
                    chk("latency", cyc, cur.start);
                    chk("bit0_ser_ena", serial_ena, 1);
                    chk("bit0_busy", busy, 1);
                    got    = '0;
                    got[0] = serial_out;
                    bidx   = 1;
                    phase  = 1;
                end
            end else if (phase == 1) begin
                chk("bit_ser_ena", serial_ena, 1);
                chk("bit_busy", busy, 1);
                got[bidx] = serial_out;
                bidx++;
                if (bidx == 7) begin
                    chk("codeword", got, cur.cw);
                    gleft = GAP;
                    phase = (GAP > 0) ? 2 : 0;
                end
            end else if (phase == 2) begin
                chk("gap_ser_ena", serial_ena, 1);
                chk("gap_out", serial_out, IDL);
                chk("gap_busy", busy, 1);
                gleft--;
                if (gleft == 0) phase = 0;
            end else begin
                chk("idle_ser_ena", serial_ena, 0);
                chk("idle_busy", busy, 0);
                chk("idle_out", serial_out, IDL);
            end
            last = {serial_out, serial_ena, frame_start, busy};
        end
    end

    initial begin : main
        rst_n      = 1'b0;
        ena        = 1'b1;
        data_in    = 4'h0;
        data_valid = 1'b0;
`ifdef ERR_INJECT_EN
        err_inject = 1'b0;
        err_pos    = 3'd7;
`endif
        #1;
        chk("reset_out", serial_out, IDL);
        chk("reset_ser_ena", serial_ena, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ready", data_ready, 0);
        chk("reset_fs", frame_start, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frames with idle time between them
        send(4'hB, 7'h33);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (10) @(negedge clk);
        send(4'h0, 7'h00);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (10) @(negedge clk);
        send(4'hF, 7'h7F);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (10) @(negedge clk);

        // Back-to-back pair with data_valid held
        ena_cnt = 0;
        fs_log.delete();
        send(4'h3, 7'h43);
        @(negedge clk);
        send(4'hC, 7'h3C);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("b2b_ena_cycles", ena_cnt, 16);
        chk("b2b_fs_count", fs_log.size(), 2);
        if (fs_log.size() == 2)
            chk("b2b_period", fs_log[1] - fs_log[0], 8);

        // All sixteen nibbles as one continuous stream
        fs_log.delete();
        for (int i = 0; i < 16; i++) begin
            send(4'(i), cw_tab[i]);
            @(negedge clk);
        end
        data_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("stream_fs_count", fs_log.size(), 16);

        // data_valid while ena low must not be accepted
        ena        = 1'b0;
        data_in    = 4'h5;
        data_valid = 1'b1;
        repeat (3) @(negedge clk);
        ena = 1'b1;
        send(4'h5, 7'h25);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (10) @(negedge clk);

        // Freeze for three cycles while bit 3 is on the line
        send(4'h9, 7'h19);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("freeze_at_bit3", serial_out, 1);
        ena = 1'b0;
        repeat (3) @(negedge clk);
        ena = 1'b1;
        repeat (10) @(negedge clk);

        // Reset while bit 4 is on the line aborts the frame
        send(4'hA, 7'h5A);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(4'h6, 7'h66);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (10) @(negedge clk);

`ifdef ERR_INJECT_EN
        err_inject = 1'b1;
        err_pos    = 3'd2;
        send(4'hB, 7'h37);
        @(negedge clk);
        data_valid = 1'b0;
        err_pos    = 3'd7;
        repeat (10) @(negedge clk);
        send(4'hF, 7'h7F);
        @(negedge clk);
        data_valid = 1'b0;
        err_inject = 1'b0;
        repeat (10) @(negedge clk);
`endif

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
